q_result_drain: RTL and testbench
=================================

Name: q_result_drain

Overview:
- Consumes the flat bank of per-slice MAC results (N x Q_W) produced by the 64-slice MAC array.
- Snapshots the whole bank on a result-valid strobe, then streams the results out one slice per beat over a valid/ready interface.
- Requantizes each beat: arithmetic right shift, optional ReLU, signed saturation to OUT_W.
- Sits between the MAC slice array and the activation write-back / next-layer input buffer.

Parameters:
- N, 64, number of slice results per bank
- Q_W, 20, width of each slice result (signed two's complement)
- OUT_W, 8, width of each streamed output (signed two's complement)
- SHIFT, 4, arithmetic right shift applied before saturation (0..Q_W-1)
- RELU, 1, 1 = clamp negative values to 0 after shifting

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- q_valid  in  1  one-cycle strobe; Q_total_flat holds a complete bank
- Q_total_flat  in  N*Q_W  slice results; slice i at [Q_W*i +: Q_W]
- out_ready  in  1  downstream accepts the beat
- clear_overrun  in  1  synchronous clear of the overrun flag
- out_valid  out  1  beat available
- out_data  out  OUT_W  requantized result for slice out_idx
- out_idx  out  $clog2(N)  slice index of the current beat
- out_last  out  1  high with out_valid when out_idx == N-1
- busy  out  1  high while in STREAM
- overrun  out  1  sticky; set when a bank was dropped

Behaviour:
- Reset: the async assert forces state=IDLE, idx=0, the shadow bank to 0, out_valid=0, out_last=0, busy=0, overrun=0. out_data reads as 0 during reset.
- FSM has two states, IDLE and STREAM.
- IDLE + q_valid: capture all N results into the shadow register, set idx=0, go to STREAM.
- Latency: q_valid at edge T gives out_valid=1 with out_idx=0 from edge T+1.
- STREAM:
  - out_valid=1 and busy=1.
  - out_data, out_idx and out_last are driven from registered state only; no combinational path from out_ready.
  - A handshake occurs on out_valid && out_ready.
  - On a handshake with idx<N-1: idx increments.
  - On a handshake with idx==N-1: go to IDLE, idx=0.
- Backpressure: while out_valid && !out_ready, out_data, out_idx and out_last hold stable.
- q_valid during STREAM, except on the last-beat handshake cycle:
  - the new bank is dropped;
  - the shadow bank is unchanged;
  - overrun is set to 1 at the next edge.
- q_valid on the same cycle as the last-beat handshake (idx==N-1 && out_ready):
  - capture the new bank, set idx=0, stay in STREAM;
  - no bubble, no overrun.
- overrun handling:
  - clear_overrun clears the flag at the next edge.
  - A simultaneous set condition wins, so overrun stays 1.
- Requantization for each beat:
  - s = Q[idx] >>> SHIFT (sign-extended);
  - if RELU and s<0, then s=0;
  - out_data = min(max(s, -2^(OUT_W-1)), 2^(OUT_W-1)-1).
- A reset assertion mid-stream aborts immediately. No partial beats are emitted after reset deasserts.

Decomposition:
- Shared package slices_pkg holds:
  - N, Q_W, OUT_W;
  - IDX_W = $clog2(N);
  - the state enum {IDLE, STREAM};
  - a requant function prototype constant set (SHIFT, RELU defaults).
- One natural combinational sub-module, q_requant: Q_W in, OUT_W out, parameters SHIFT and RELU. It implements the shift, ReLU and saturation.
- The FSM, index counter, shadow register and overrun logic stay in q_result_drain.

Test Plan:
- Basic drain: load Q[0]=100, Q[1]=5000, Q[2]=-80, all others i, with out_ready=1 and RELU=1 -> 64 consecutive beats starting 1 cycle after q_valid. Beat data: 6, 127, 0, then i>>4. out_last is high only on idx 63, then busy drops.
- RELU=0 instance: Q[2]=-80 gives out_data=8'hFB (-5); Q[3]=-20'd40000 gives 8'h80 (-128).
- Backpressure: toggle out_ready 1,0,0,1 every cycle -> out_data and out_idx hold while ready is low. All 64 beats arrive in order with no duplicates or skips.
- Overrun: second q_valid at idx=10 -> stream continues with the original bank and overrun=1. Pulsing clear_overrun then sets overrun=0.
- Back-to-back: q_valid on the idx=63 handshake cycle -> the next cycle shows idx=0 from the new bank, no idle bubble, and overrun stays 0.
- Reset mid-stream: assert reset at idx=20 -> out_valid=0, busy=0, idx=0 immediately. After release, no beats appear until the next q_valid.

Source files
------------

// File: rtl/q_result_drain_pkg.sv
// q_result_drain_pkg: shared sizes, FSM state type and requant defaults for the slice result drain.
package slices_pkg;
    localparam int N        = 64;
    localparam int Q_W      = 20;
    localparam int OUT_W    = 8;
    localparam int IDX_W    = $clog2(N);
    localparam int RQ_SHIFT = 4;
    localparam int RQ_RELU  = 1;
    typedef enum logic {IDLE, STREAM} state_t;
endpackage

// File: rtl/q_result_drain_if.sv
// q_result_drain_if: bank input strobe plus valid/ready result stream of the drain.
interface q_result_drain_if;
    import slices_pkg::*;
    logic                   q_valid;
    logic [N*Q_W-1:0]       Q_total_flat;
    logic                   out_ready;
    logic                   clear_overrun;
    logic                   out_valid;
    logic [OUT_W-1:0]       out_data;
    logic [IDX_W-1:0]       out_idx;
    logic                   out_last;
    logic                   busy;
    logic                   overrun;
    modport master (
        output q_valid, Q_total_flat, out_ready, clear_overrun,
        input  out_valid, out_data, out_idx, out_last, busy, overrun
    );
    modport slave (
        input  q_valid, Q_total_flat, out_ready, clear_overrun,
        output out_valid, out_data, out_idx, out_last, busy, overrun
    );
endinterface

// File: rtl/q_result_drain_requant.sv
// q_requant: arithmetic right shift, optional ReLU and signed saturation of one slice result.
module q_requant
    import slices_pkg::*;
#(
    parameter int SHIFT = RQ_SHIFT,
    parameter int RELU  = RQ_RELU
) (
    input  logic [Q_W-1:0]   q_i,
    output logic [OUT_W-1:0] d_o
);
    localparam logic signed [Q_W-1:0] MAXV = Q_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [Q_W-1:0] MINV = ~MAXV;
    logic signed [Q_W-1:0] s, r;
    assign s   = $signed(q_i) >>> SHIFT;
    assign r   = (RELU != 0 && s < 0) ? '0 : s;
    assign d_o = r > MAXV ? OUT_W'(MAXV) : r < MINV ? OUT_W'(MINV) : r[OUT_W-1:0];
endmodule

// File: rtl/q_result_drain.sv
// q_result_drain: snapshots a bank of slice MAC results and streams them out requantized, one slice per beat.
module q_result_drain
    import slices_pkg::*;
#(
    parameter int SHIFT = RQ_SHIFT,
    parameter int RELU  = RQ_RELU
) (
    input  logic         clk,
    input  logic         reset,
    q_result_drain_if.slave bus
);
    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N*Q_W-1:0] bank_q, bank_d;
    logic             ovr_q, ovr_d;
    logic             last, hs, start, drop;
    // A bank arriving on the final handshake is taken without a bubble; any other mid-stream bank is dropped.
    always_comb begin
        last    = idx_q == IDX_W'(N - 1);
        hs      = state_q == STREAM && bus.out_ready;
        start   = bus.q_valid && (state_q == IDLE || (hs && last));
        drop    = bus.q_valid && state_q == STREAM && !(hs && last);
        state_d = start ? STREAM : (hs && last) ? IDLE : state_q;
        idx_d   = (start || (hs && last)) ? '0 : hs ? idx_q + 1'b1 : idx_q;
        bank_d  = start ? bus.Q_total_flat : bank_q;
        ovr_d   = drop || (ovr_q && !bus.clear_overrun);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            bank_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            bank_q  <= bank_d;
            ovr_q   <= ovr_d;
        end
    end
    assign bus.out_valid = state_q == STREAM;
    assign bus.busy      = state_q == STREAM;
    assign bus.out_last  = state_q == STREAM && last;
    assign bus.out_idx   = idx_q;
    assign bus.overrun   = ovr_q;
    q_requant #(.SHIFT(SHIFT), .RELU(RELU)) u_requant (
        .q_i (bank_q[Q_W*idx_q +: Q_W]),
        .d_o (bus.out_data)
    );
endmodule

// File: tb/tb_q_result_drain.sv
// tb_q_result_drain: directed scenarios on a ReLU and a non-ReLU drain sharing one stimulus stream.
module tb_q_result_drain;
    import slices_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int passed = 0;
    always #5 clk = ~clk;
    q_result_drain_if bus ();
    q_result_drain_if nr ();
    assign nr.q_valid       = bus.q_valid;
    assign nr.Q_total_flat  = bus.Q_total_flat;
    assign nr.out_ready     = bus.out_ready;
    assign nr.clear_overrun = bus.clear_overrun;
    q_result_drain dut (.clk(clk), .reset(reset), .bus(bus.slave));
    q_result_drain #(.RELU(0)) dut_nr (.clk(clk), .reset(reset), .bus(nr.slave));

    function automatic logic [N*Q_W-1:0] bank_a();
        logic [N*Q_W-1:0] f;
        for (int i = 0; i < N; i++) f[Q_W*i +: Q_W] = Q_W'(i);
        f[0 +: Q_W]     = Q_W'(100);
        f[Q_W +: Q_W]   = Q_W'(5000);
        f[2*Q_W +: Q_W] = Q_W'(-80);
        return f;
    endfunction

    function automatic logic [N*Q_W-1:0] bank_b();
        logic [N*Q_W-1:0] f;
        for (int i = 0; i < N; i++) f[Q_W*i +: Q_W] = Q_W'(32 * i + 16);
        return f;
    endfunction

    // hand-derived beats of bank_a on the ReLU instance
    function automatic logic [OUT_W-1:0] exp_a(int i);
        if (i == 0) return 8'd6;
        if (i == 1) return 8'd127;
        if (i == 2) return 8'd0;
        return OUT_W'(i / 16);
    endfunction

    task automatic pulse_q(input logic [N*Q_W-1:0] b);
        bus.Q_total_flat = b;
        bus.q_valid = 1'b1;
        @(negedge clk);
        bus.q_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset out_valid got %0b want 0", bus.out_valid); else passed++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL reset busy got %0b want 0", bus.busy); else passed++;
        checks++; if (bus.overrun !== 1'b0) $display("FAIL reset overrun got %0b want 0", bus.overrun); else passed++;
        checks++; if (bus.out_last !== 1'b0) $display("FAIL reset out_last got %0b want 0", bus.out_last); else passed++;
        checks++; if (bus.out_idx !== '0) $display("FAIL reset out_idx got %0d want 0", bus.out_idx); else passed++;
        checks++; if (bus.out_data !== '0) $display("FAIL reset out_data got %h want 00", bus.out_data); else passed++;
        reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL idle out_valid got %0b want 0", bus.out_valid); else passed++;
    endtask

    task automatic test_basic();
        bus.out_ready = 1'b1;
        pulse_q(bank_a());
        for (int i = 0; i < N; i++) begin
            checks++; if (bus.out_valid !== 1'b1 || bus.out_idx !== IDX_W'(i)) $display("FAIL basic idx got v=%0b %0d want v=1 %0d", bus.out_valid, bus.out_idx, i); else passed++;
            checks++; if (bus.out_data !== exp_a(i)) $display("FAIL basic data[%0d] got %h want %h", i, bus.out_data, exp_a(i)); else passed++;
            checks++; if (bus.out_last !== (i == N - 1)) $display("FAIL basic last[%0d] got %0b", i, bus.out_last); else passed++;
            checks++; if (bus.busy !== 1'b1) $display("FAIL basic busy[%0d] got %0b want 1", i, bus.busy); else passed++;
            @(negedge clk);
        end
        checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) $display("FAIL basic end got v=%0b busy=%0b want 0 0", bus.out_valid, bus.busy); else passed++;
    endtask

    task automatic test_norelu();
        logic [N*Q_W-1:0] b;
        b = bank_a();
        b[3*Q_W +: Q_W] = Q_W'(-40000);
        pulse_q(b);
        for (int i = 0; i < N; i++) begin
            if (i == 2) begin
                checks++; if (nr.out_data !== 8'hFB) $display("FAIL norelu neg80 got %h want fb", nr.out_data); else passed++;
                checks++; if (bus.out_data !== 8'h00) $display("FAIL relu neg80 got %h want 00", bus.out_data); else passed++;
            end
            if (i == 3) begin
                checks++; if (nr.out_data !== 8'h80) $display("FAIL norelu neg40000 got %h want 80", nr.out_data); else passed++;
                checks++; if (bus.out_data !== 8'h00) $display("FAIL relu neg40000 got %h want 00", bus.out_data); else passed++;
            end
            if (i == 1) begin
                checks++; if (nr.out_data !== 8'h7F) $display("FAIL norelu pos5000 got %h want 7f", nr.out_data); else passed++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int e = 0;
        int c = 0;
        pulse_q(bank_a());
        while (e < N && c < 400) begin
            bus.out_ready = pat[c % 4];
            checks++; if (bus.out_valid !== 1'b1 || bus.out_idx !== IDX_W'(e)) $display("FAIL bp idx got v=%0b %0d want v=1 %0d", bus.out_valid, bus.out_idx, e); else passed++;
            checks++; if (bus.out_data !== exp_a(e)) $display("FAIL bp data[%0d] got %h want %h", e, bus.out_data, exp_a(e)); else passed++;
            checks++; if (bus.out_last !== (e == N - 1)) $display("FAIL bp last[%0d] got %0b", e, bus.out_last); else passed++;
            if (bus.out_ready) e++;
            c++;
            @(negedge clk);
        end
        checks++; if (e != N) $display("FAIL bp timeout got %0d beats want %0d", e, N); else passed++;
        bus.out_ready = 1'b1;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL bp end out_valid got %0b want 0", bus.out_valid); else passed++;
    endtask

    task automatic test_overrun();
        pulse_q(bank_a());
        for (int i = 0; i < N; i++) begin
            checks++; if (bus.out_idx !== IDX_W'(i) || bus.out_data !== exp_a(i)) $display("FAIL ovr beat got %0d/%h want %0d/%h", bus.out_idx, bus.out_data, i, exp_a(i)); else passed++;
            checks++; if (bus.overrun !== (i > 10)) $display("FAIL ovr flag[%0d] got %0b want %0b", i, bus.overrun, i > 10); else passed++;
            if (i == 10) begin
                bus.Q_total_flat = bank_b();
                bus.q_valid = 1'b1;
            end
            if (i == 20) begin
                bus.q_valid = 1'b1;
                bus.clear_overrun = 1'b1;
            end
            @(negedge clk);
            bus.q_valid = 1'b0;
            bus.clear_overrun = 1'b0;
        end
        checks++; if (bus.out_valid !== 1'b0 || bus.overrun !== 1'b1) $display("FAIL ovr end got v=%0b ovr=%0b want 0 1", bus.out_valid, bus.overrun); else passed++;
        bus.clear_overrun = 1'b1;
        @(negedge clk);
        bus.clear_overrun = 1'b0;
        checks++; if (bus.overrun !== 1'b0) $display("FAIL ovr clear got %0b want 0", bus.overrun); else passed++;
    endtask

    task automatic test_back_to_back();
        pulse_q(bank_a());
        for (int i = 0; i < N; i++) begin
            if (i == N - 1) begin
                checks++; if (bus.out_last !== 1'b1) $display("FAIL b2b last got %0b want 1", bus.out_last); else passed++;
                bus.Q_total_flat = bank_b();
                bus.q_valid = 1'b1;
            end
            @(negedge clk);
            bus.q_valid = 1'b0;
        end
        for (int j = 0; j < N; j++) begin
            checks++; if (bus.out_valid !== 1'b1 || bus.out_idx !== IDX_W'(j)) $display("FAIL b2b idx got v=%0b %0d want v=1 %0d", bus.out_valid, bus.out_idx, j); else passed++;
            checks++; if (bus.out_data !== OUT_W'(2 * j + 1)) $display("FAIL b2b data[%0d] got %h want %h", j, bus.out_data, OUT_W'(2 * j + 1)); else passed++;
            if (j == 0) begin
                checks++; if (bus.overrun !== 1'b0) $display("FAIL b2b overrun got %0b want 0", bus.overrun); else passed++;
            end
            @(negedge clk);
        end
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL b2b end out_valid got %0b want 0", bus.out_valid); else passed++;
    endtask

    task automatic test_reset_mid();
        pulse_q(bank_a());
        repeat (20) @(negedge clk);
        checks++; if (bus.out_idx !== IDX_W'(20)) $display("FAIL rst pre idx got %0d want 20", bus.out_idx); else passed++;
        reset = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) $display("FAIL rst mid got v=%0b busy=%0b want 0 0", bus.out_valid, bus.busy); else passed++;
        checks++; if (bus.out_idx !== '0 || bus.out_data !== '0) $display("FAIL rst mid got idx=%0d data=%h want 0 00", bus.out_idx, bus.out_data); else passed++;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst after[%0d] out_valid got %0b want 0", k, bus.out_valid); else passed++;
        end
        pulse_q(bank_b());
        checks++; if (bus.out_valid !== 1'b1 || bus.out_idx !== '0 || bus.out_data !== 8'd1) $display("FAIL rst restart got v=%0b %0d/%h want 1 0/01", bus.out_valid, bus.out_idx, bus.out_data); else passed++;
    endtask

    initial begin
        bus.q_valid = 1'b0;
        bus.Q_total_flat = '0;
        bus.out_ready = 1'b1;
        bus.clear_overrun = 1'b0;
        test_reset();
        test_basic();
        test_norelu();
        test_backpressure();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
